// File: rtl/data_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_if
// Purpose : groups the two requester handshakes and the data_memory bus of the
//           data_memory_arbiter into one interface.
// Signals : a_* / b_*   requester A (CPU load/store) and B (loader/DMA):
//                       req, we, addr, wdata in; ack, rdata out
//           mem_*       address, data_write, rw (read_write_selector) out,
//                       data_read in
//           busy        arbiter is in a state other than IDLE
// Modports: slave  - arbiter side
//           master - requesters + memory side (testbench / system top)
// Widths come from `MEMORY_ADDR_VEC / `WORD_VEC (normally defines.vh); the
// guarded defaults below apply only when those macros are not predefined.
// -----------------------------------------------------------------------------
`ifndef MEMORY_ADDR_VEC
`define MEMORY_ADDR_VEC [7:0]
`endif
`ifndef WORD_VEC
`define WORD_VEC [31:0]
`endif
`ifndef MEMORY_READ
`define MEMORY_READ 1'b0
`endif
`ifndef MEMORY_WRITE
`define MEMORY_WRITE 1'b1
`endif

interface data_memory_arbiter_if;
  logic                  a_req;
  logic                  a_we;
  logic `MEMORY_ADDR_VEC a_addr;
  logic `WORD_VEC        a_wdata;
  logic                  a_ack;
  logic `WORD_VEC        a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic `MEMORY_ADDR_VEC b_addr;
  logic `WORD_VEC        b_wdata;
  logic                  b_ack;
  logic `WORD_VEC        b_rdata;

  logic `MEMORY_ADDR_VEC mem_address;
  logic `WORD_VEC        mem_data_write;
  logic                  mem_rw;
  logic `WORD_VEC        mem_data_read;
  logic                  busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_data_read,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_address, mem_data_write, mem_rw, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_data_read,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_address, mem_data_write, mem_rw, busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Purpose : shares one single-port data_memory between requester A (CPU
//           load/store) and requester B (loader/DMA). One transaction per
//           grant, FSM IDLE -> ACCESS -> RESP -> IDLE. Requests are sampled
//           only in IDLE; the winner's ack pulses in RESP, two cycles after
//           the sampling cycle.
// Ports   : clk    - single clock, all state on posedge
//           reset  - synchronous, active-high
//           bus    - data_memory_arbiter_if.slave (requesters + memory bus)
// Config  : DMEM_ARB_FIXED_PRIO_EN defined   -> ties always go to A
//           DMEM_ARB_FIXED_PRIO_EN undefined -> ties alternate (round-robin),
//                                              A wins the first tie after reset
// All outputs are registered; the memory bus is loaded on the IDLE->ACCESS
// transition so it is non-zero only during the ACCESS cycle.
// -----------------------------------------------------------------------------
`ifndef MEMORY_ADDR_VEC
`define MEMORY_ADDR_VEC [7:0]
`endif
`ifndef WORD_VEC
`define WORD_VEC [31:0]
`endif
`ifndef MEMORY_READ
`define MEMORY_READ 1'b0
`endif
`ifndef MEMORY_WRITE
`define MEMORY_WRITE 1'b1
`endif

module data_memory_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t                r_state;
  state_t                w_next_state;

  // latched transaction
  logic                  r_winner;
  logic                  r_we;
  logic `MEMORY_ADDR_VEC r_addr;
  logic `WORD_VEC        r_wdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                  r_last_grant;
`endif

  // registered outputs
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic                  r_busy;
  logic                  r_mem_rw;
  logic `MEMORY_ADDR_VEC r_mem_address;
  logic `WORD_VEC        r_mem_data_write;
  logic `WORD_VEC        r_a_rdata;
  logic `WORD_VEC        r_b_rdata;

  // next-state / next-output values
  logic                  w_any_req;
  logic                  w_grant_b;
  logic                  w_sel_we;
  logic `MEMORY_ADDR_VEC w_sel_addr;
  logic `WORD_VEC        w_sel_wdata;
  logic                  w_latch;
  logic                  w_a_ack_nxt;
  logic                  w_b_ack_nxt;
  logic                  w_busy_nxt;
  logic                  w_mem_rw_nxt;
  logic `MEMORY_ADDR_VEC w_mem_address_nxt;
  logic `WORD_VEC        w_mem_data_write_nxt;
  logic                  w_capture_a;
  logic                  w_capture_b;

  assign w_any_req = bus.a_req | bus.b_req;

  // Arbitration: a lone request wins; a tie goes by configured policy.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    w_grant_b = ~bus.a_req;
`else
    if (bus.a_req && bus.b_req) begin
      w_grant_b = (r_last_grant == GRANT_A);
    end else begin
      w_grant_b = ~bus.a_req;
    end
`endif
  end

  // Mux the winning requester's transaction fields.
  always_comb begin
    if (w_grant_b) begin
      w_sel_we    = bus.b_we;
      w_sel_addr  = bus.b_addr;
      w_sel_wdata = bus.b_wdata;
    end else begin
      w_sel_we    = bus.a_we;
      w_sel_addr  = bus.a_addr;
      w_sel_wdata = bus.a_wdata;
    end
  end

  // FSM next state and next values of the registered outputs.
  always_comb begin
    w_next_state         = r_state;
    w_latch              = 1'b0;
    w_a_ack_nxt          = 1'b0;
    w_b_ack_nxt          = 1'b0;
    w_mem_rw_nxt         = `MEMORY_READ;
    w_mem_address_nxt    = '0;
    w_mem_data_write_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next_state         = ST_ACCESS;
          w_latch              = 1'b1;
          // bus values for the upcoming ACCESS cycle
          w_mem_address_nxt    = w_sel_addr;
          w_mem_data_write_nxt = w_sel_wdata;
          w_mem_rw_nxt         = w_sel_we ? `MEMORY_WRITE : `MEMORY_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_next_state = ST_RESP;
        w_a_ack_nxt  = (r_winner == GRANT_A);
        w_b_ack_nxt  = (r_winner == GRANT_B);
      end
      ST_RESP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_next_state != ST_IDLE);
  end

  assign w_capture_a = (r_state == ST_ACCESS) && !r_we && (r_winner == GRANT_A);
  assign w_capture_b = (r_state == ST_ACCESS) && !r_we && (r_winner == GRANT_B);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the granted transaction and remember who was served.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_winner     <= GRANT_A;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      r_last_grant <= GRANT_B;
`endif
    end else if (w_latch) begin
      r_winner     <= w_grant_b;
      r_we         <= w_sel_we;
      r_addr       <= w_sel_addr;
      r_wdata      <= w_sel_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      r_last_grant <= w_grant_b;
`endif
    end
  end

  // Registered handshake and memory-bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_ack          <= 1'b0;
      r_b_ack          <= 1'b0;
      r_busy           <= 1'b0;
      r_mem_rw         <= `MEMORY_READ;
      r_mem_address    <= '0;
      r_mem_data_write <= '0;
    end else begin
      r_a_ack          <= w_a_ack_nxt;
      r_b_ack          <= w_b_ack_nxt;
      r_busy           <= w_busy_nxt;
      r_mem_rw         <= w_mem_rw_nxt;
      r_mem_address    <= w_mem_address_nxt;
      r_mem_data_write <= w_mem_data_write_nxt;
    end
  end

  // Read data registers; only the winner's register changes, and only on reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (w_capture_a) begin
        r_a_rdata <= bus.mem_data_read;
      end
      if (w_capture_b) begin
        r_b_rdata <= bus.mem_data_read;
      end
    end
  end

  assign bus.a_ack          = r_a_ack;
  assign bus.b_ack          = r_b_ack;
  assign bus.a_rdata        = r_a_rdata;
  assign bus.b_rdata        = r_b_rdata;
  assign bus.busy           = r_busy;
  assign bus.mem_rw         = r_mem_rw;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_data_write = r_mem_data_write;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
// Self-checking bench for data_memory_arbiter: reset state, a table of single
// transactions, hand-written multi-cycle sequences (tie alternation, reset in
// ACCESS, early req drop) and a random two-requester run checked against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
`ifndef MEMORY_ADDR_VEC
`define MEMORY_ADDR_VEC [7:0]
`endif
`ifndef WORD_VEC
`define WORD_VEC [31:0]
`endif
`ifndef MEMORY_READ
`define MEMORY_READ 1'b0
`endif
`ifndef MEMORY_WRITE
`define MEMORY_WRITE 1'b1
`endif

module tb_data_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;

  always #5 clk = ~clk;

  data_memory_arbiter_if bus();

  data_memory_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // simple data_memory: combinational read, write on posedge
  logic `WORD_VEC mem [0:255];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.mem_rw == `MEMORY_WRITE) begin
      mem[bus.mem_address] <= bus.mem_data_write;
    end
  end

  assign bus.mem_data_read = mem[bus.mem_address];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] shadow [0:1];

  typedef struct {
    logic        who;   // 0 = A, 1 = B
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 8'h0; bus.a_wdata = 32'h0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 8'h0; bus.b_wdata = 32'h0;
  endtask

  function automatic logic ack_of(input logic who);
    return who ? bus.b_ack : bus.a_ack;
  endfunction

  function automatic logic [31:0] rd_of(input logic who);
    return who ? bus.b_rdata : bus.a_rdata;
  endfunction

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1; mem_clear = 1'b1;
    tick(); tick();
    reset = 1'b0; mem_clear = 1'b0;
    shadow[0] = 32'h0; shadow[1] = 32'h0;
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_a_ack", 32'(bus.a_ack), 32'h0);
    chk("rst_b_ack", 32'(bus.b_ack), 32'h0);
    chk("rst_rw",    32'(bus.mem_rw), 32'(`MEMORY_READ));
    chk("rst_addr",  32'(bus.mem_address), 32'h0);
    chk("rst_wdata", bus.mem_data_write, 32'h0);
    chk("rst_a_rd",  bus.a_rdata, 32'h0);
    chk("rst_b_rd",  bus.b_rdata, 32'h0);
  endtask

  // one isolated transaction from an idle arbiter, checked cycle by cycle
  task automatic run_txn(input vec_t v);
    if (!v.who) begin
      bus.a_req = 1'b1; bus.a_we = v.we; bus.a_addr = v.addr; bus.a_wdata = v.wdata;
    end else begin
      bus.b_req = 1'b1; bus.b_we = v.we; bus.b_addr = v.addr; bus.b_wdata = v.wdata;
    end
    tick(); // ACCESS
    chk("acc_busy",  32'(bus.busy), 32'h1);
    chk("acc_rw",    32'(bus.mem_rw), v.we ? 32'(`MEMORY_WRITE) : 32'(`MEMORY_READ));
    chk("acc_addr",  32'(bus.mem_address), 32'(v.addr));
    chk("acc_wdata", bus.mem_data_write, v.wdata);
    chk("acc_noack", 32'(bus.a_ack | bus.b_ack), 32'h0);
    tick(); // RESP
    chk("rsp_busy",  32'(bus.busy), 32'h1);
    chk("rsp_rw",    32'(bus.mem_rw), 32'(`MEMORY_READ));
    chk("rsp_addr",  32'(bus.mem_address), 32'h0);
    chk("rsp_ack",   32'(ack_of(v.who)), 32'h1);
    chk("rsp_other_ack", 32'(ack_of(!v.who)), 32'h0);
    chk("rsp_rdata", rd_of(v.who), v.exp_rd);
    chk("rsp_other_rdata", rd_of(!v.who), shadow[!v.who]);
    shadow[v.who] = v.exp_rd;
    idle_inputs();
    tick(); // IDLE
    chk("idle_busy", 32'(bus.busy), 32'h0);
    chk("idle_ack",  32'(bus.a_ack | bus.b_ack), 32'h0);
  endtask

  // random-phase model state
  int          idle_from, access_cycle, ack_cycle;
  bit          pend, pend_who, pend_we, last_b, a_act, b_act;
  logic [7:0]  cur_addr;
  logic [31:0] cur_wdata, rd_val;
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_rd [0:1];
  bit          e_a_ack, e_b_ack, win_b;
  logic        exp_a;

  initial begin
    reset = 1'b1;
    mem_clear = 1'b1;
    idle_inputs();

    // who, we, addr, wdata, expected rdata of that requester in its ack cycle
    vecs[0]  = '{1'b0, 1'b1, 8'd5,   32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b0, 8'd5,   32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 8'd7,   32'h0000_1234, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 8'd7,   32'h0000_0000, 32'h0000_1234};
    vecs[4]  = '{1'b0, 1'b0, 8'd7,   32'h0000_0000, 32'h0000_1234};
    vecs[5]  = '{1'b1, 1'b0, 8'd5,   32'h0000_0000, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 8'd255, 32'hA5A5_A5A5, 32'h0000_1234};
    vecs[7]  = '{1'b1, 1'b0, 8'd255, 32'h0000_0000, 32'hA5A5_A5A5};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,   32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b1, 8'd0,   32'hFFFF_FFFF, 32'hA5A5_A5A5};
    vecs[10] = '{1'b0, 1'b0, 8'd0,   32'h0000_0000, 32'hFFFF_FFFF};

    do_reset();
    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // both requesters hold reads continuously
    do_reset();
    bus.a_req = 1'b1; bus.a_addr = 8'd1;
    bus.b_req = 1'b1; bus.b_addr = 8'd2;
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_a = ((c % 3) == 2);
      chk("tie_a_ack", 32'(bus.a_ack), 32'(exp_a));
      chk("tie_b_ack", 32'(bus.b_ack), 32'h0);
`else
      exp_a = ((c % 3) == 2) && (((c / 3) % 2) == 0);
      chk("tie_a_ack", 32'(bus.a_ack), 32'(exp_a));
      chk("tie_b_ack", 32'(bus.b_ack), 32'(((c % 3) == 2) && !exp_a));
`endif
      if (c == 12) idle_inputs();
    end
    tick();
    chk("tie_end_busy", 32'(bus.busy), 32'h0);

    // reset during ACCESS of an A write aborts the transaction
    do_reset();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'd9; bus.a_wdata = 32'h0000_0077;
    tick();
    chk("abort_acc_rw", 32'(bus.mem_rw), 32'(`MEMORY_WRITE));
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    chk("abort_busy",  32'(bus.busy), 32'h0);
    chk("abort_a_ack", 32'(bus.a_ack), 32'h0);
    chk("abort_rw",    32'(bus.mem_rw), 32'(`MEMORY_READ));
    chk("abort_addr",  32'(bus.mem_address), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_stale_ack", 32'(bus.a_ack | bus.b_ack | bus.busy), 32'h0);
    end

    // A write to addr 3 with req dropped after one cycle
    do_reset();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'd3; bus.a_wdata = 32'hCAFE_0003;
    tick();
    idle_inputs();
    tick();
    chk("drop_a_ack", 32'(bus.a_ack), 32'h1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("drop_no_regrant", 32'(bus.a_ack | bus.busy), 32'h0);
    end
    chk("drop_mem3", mem[3], 32'hCAFE_0003);

    // random two-requester run against the transaction-level model
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    idle_from = 0; access_cycle = -1; ack_cycle = -1;
    pend = 1'b0; last_b = 1'b1; a_act = 1'b0; b_act = 1'b0;
    pend_who = 1'b0; pend_we = 1'b0; cur_addr = 8'h0; cur_wdata = 32'h0; rd_val = 32'h0;
    for (int c = 0; c < 900; c++) begin
      e_a_ack = pend && (ack_cycle == c) && !pend_who;
      e_b_ack = pend && (ack_cycle == c) &&  pend_who;
      if (pend && (ack_cycle == c)) begin
        if (!pend_we) exp_rd[pend_who] = rd_val;
        pend = 1'b0;
      end
      chk("rnd_a_ack", 32'(bus.a_ack), 32'(e_a_ack));
      chk("rnd_b_ack", 32'(bus.b_ack), 32'(e_b_ack));
      chk("rnd_busy",  32'(bus.busy), 32'(c < idle_from));
      chk("rnd_rw",    32'(bus.mem_rw),
          (c == access_cycle && pend_we) ? 32'(`MEMORY_WRITE) : 32'(`MEMORY_READ));
      chk("rnd_addr",  32'(bus.mem_address), (c == access_cycle) ? 32'(cur_addr) : 32'h0);
      chk("rnd_wdata", bus.mem_data_write, (c == access_cycle) ? cur_wdata : 32'h0);
      chk("rnd_a_rdata", bus.a_rdata, exp_rd[0]);
      chk("rnd_b_rdata", bus.b_rdata, exp_rd[1]);

      // requesters: hold until ack, then maybe issue the next transaction
      if (e_a_ack) begin a_act = 1'b0; bus.a_req = 1'b0; end
      if (e_b_ack) begin b_act = 1'b0; bus.b_req = 1'b0; end
      if (!a_act && ($urandom_range(0, 2) == 0)) begin
        a_act = 1'b1; bus.a_req = 1'b1; bus.a_we = 1'($urandom_range(0, 1));
        bus.a_addr = 8'($urandom_range(16, 23)); bus.a_wdata = $urandom;
      end
      if (!b_act && ($urandom_range(0, 2) == 0)) begin
        b_act = 1'b1; bus.b_req = 1'b1; bus.b_we = 1'($urandom_range(0, 1));
        bus.b_addr = 8'($urandom_range(16, 23)); bus.b_wdata = $urandom;
      end

      // model: a grant happens only when the arbiter is idle this cycle
      if ((c >= idle_from) && (bus.a_req || bus.b_req)) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win_b = !bus.a_req;
`else
        win_b = (bus.a_req && bus.b_req) ? !last_b : !bus.a_req;
        last_b = win_b;
`endif
        pend_who  = win_b;
        pend_we   = win_b ? bus.b_we : bus.a_we;
        cur_addr  = win_b ? bus.b_addr : bus.a_addr;
        cur_wdata = win_b ? bus.b_wdata : bus.a_wdata;
        if (pend_we) ref_mem[cur_addr] = cur_wdata;
        else         rd_val = ref_mem[cur_addr];
        pend = 1'b1;
        access_cycle = c + 1;
        ack_cycle    = c + 2;
        idle_from    = c + 3;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameters: none; widths SHALL come from `MEMORY_ADDR_VEC (address) and `WORD_VEC (data) in defines.vh.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req / b_req  input  1 each  requester A (CPU load/store) / B (loader/DMA) transaction request, held until ack.
REQ-005 a_we / b_we  input  1 each  1 = write, 0 = read; stable while req high.
REQ-006 a_addr / b_addr  input  `MEMORY_ADDR_VEC each  word address.
REQ-007 a_wdata / b_wdata  input  `WORD_VEC each  write data.
REQ-008 a_ack / b_ack  output  1 each  one-cycle completion pulse.
REQ-009 a_rdata / b_rdata  output  `WORD_VEC each  read data, valid in ack cycle, held until next own ack.
REQ-010 mem_address  output  `MEMORY_ADDR_VEC  to data_memory address.
REQ-011 mem_data_write  output  `WORD_VEC  to data_memory data_write.
REQ-012 mem_rw  output  1  to data_memory read_write_selector (`MEMORY_READ / `MEMORY_WRITE).
REQ-013 mem_data_read  input  `WORD_VEC  from data_memory data_read.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP; one transaction per grant.
REQ-016 IDLE: requests sampled only here; if any req, latch winner id, we, addr, wdata into internal registers and go to ACCESS; else stay.
REQ-017 Arbitration: single req wins; both req -> grant the requester not in last_grant (round-robin); last_grant updated on every grant.
REQ-018 ACCESS: drive mem_address/mem_data_write from latched registers; mem_rw = `MEMORY_WRITE iff latched we, else `MEMORY_READ; capture mem_data_read into winner's rdata register on read; go to RESP.
REQ-019 mem_rw SHALL be `MEMORY_READ in IDLE and RESP; no memory write outside ACCESS.
REQ-020 mem_address/mem_data_write SHALL be 0 outside ACCESS.
REQ-021 RESP: assert winner's ack for exactly one cycle; go to IDLE; loser ack stays 0.
REQ-022 Latency: req high in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2; next grant earliest at N+3 sampling.
REQ-023 Write transactions SHALL leave the requester's rdata register unchanged.
REQ-024 Requester dropping req before ack: already-latched transaction still completes and acks; unlatched request is ignored.
REQ-025 A requester holding req after its ack is treated as a new request in the following IDLE (back-to-back allowed, subject to REQ-017).

Reset
REQ-026 reset SHALL force IDLE, a_ack=b_ack=0, busy=0, mem_rw=`MEMORY_READ, mem_address=0, mem_data_write=0, a_rdata=b_rdata=0, last_grant=B (A wins first tie).
REQ-027 reset asserted in ACCESS SHALL abort: no ack issued, transaction lost, no stale ack after release.

Configuration
REQ-028 Macro DMEM_ARB_FIXED_PRIO_EN: defined -> tie resolved always to A (fixed priority), last_grant unused; undefined -> round-robin per REQ-017.

Verification
REQ-029 Reset, then a_req=1, a_we=1, a_addr=5, a_wdata=32'hDEAD_BEEF -> mem_rw=WRITE only in ACCESS cycle, a_ack at cycle 2; then A read addr 5 -> a_rdata=32'hDEAD_BEEF with a_ack.
REQ-030 a_req and b_req both held continuously (reads, addr 1 / addr 2) -> acks alternate A,B,A,B, one ack every 3 cycles; with DMEM_ARB_FIXED_PRIO_EN -> only a_ack pulses.
REQ-031 B writes 32'h1234 to addr 7 while A idle -> b_ack at cycle 2, a_ack=0, a_rdata unchanged, busy high for cycles 1-2.
REQ-032 Assert reset during ACCESS of an A write -> next cycle IDLE, no a_ack, mem_rw=READ, busy=0.
REQ-033 A write to addr 3 with req dropped after one cycle -> a_ack still pulses once; no second grant.
